// File: rtl/branch_predictor.sv
// Bimodal branch predictor with a direct-mapped BTB and saturating branch/miss counters.
// Fetch lookup is combinational from table state; Execute resolution trains the table.
module branch_predictor #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ENTRIES    = 16,
  parameter int unsigned CTR_W      = 2,
  parameter int unsigned PREDICT_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            UpdateE,
  input  logic [XLEN-1:0] PCE,
  input  logic            TakenE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  output logic            MispredictE,
  output logic [XLEN-1:0] RedirectPCE,
  output logic [31:0]     BranchCount,
  output logic [31:0]     MissCount
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;
  localparam logic             PredEn    = (PREDICT_EN != 0);
  localparam logic [CTR_W-1:0] CtrWeakT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CtrWeakNt = CtrWeakT - CTR_W'(1);
  localparam logic [CTR_W-1:0] CtrMax    = '1;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0] ctr_q    [ENTRIES];

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;

  logic             wr_en;
  logic [TAG_W-1:0] wr_tag;
  logic [XLEN-1:0]  wr_target;
  logic [CTR_W-1:0] wr_ctr;

  // Low PC bits are instruction alignment only and never index or tag the table.
  logic unused_pc_lo;
  assign unused_pc_lo = ^{PCF[1:0], PCE[1:0]};

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[XLEN-1:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[XLEN-1:IDX_W+2];

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  assign PredTakenF  = PredEn && hit_f && ctr_q[idx_f][CTR_W-1];
  assign PredTargetF = PredTakenF ? target_q[idx_f] : '0;

  assign MispredictE = UpdateE && ((PredTakenE != TakenE) ||
                                   (TakenE && PredTakenE && (PredTargetE != PCTargetE)));
  assign RedirectPCE = TakenE ? PCTargetE : (PCE + XLEN'(4));

  assign BranchCount = branch_cnt_q;
  assign MissCount   = miss_cnt_q;

  always_comb begin
    wr_en     = 1'b0;
    wr_tag    = tag_q[idx_e];
    wr_target = target_q[idx_e];
    wr_ctr    = ctr_q[idx_e];
    if (UpdateE) begin
      if (hit_e) begin
        wr_en = 1'b1;
        if (TakenE) begin
          wr_target = PCTargetE;
          if (ctr_q[idx_e] != CtrMax) wr_ctr = ctr_q[idx_e] + CTR_W'(1);
        end else if (ctr_q[idx_e] != '0) begin
          wr_ctr = ctr_q[idx_e] - CTR_W'(1);
        end
      end else if (TakenE) begin
        // Taken miss replaces whatever alias lived at this index.
        wr_en     = 1'b1;
        wr_tag    = tag_e;
        wr_target = PCTargetE;
        wr_ctr    = CtrWeakT;
      end
    end
  end

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (UpdateE) begin
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + 32'd1;
      if (MispredictE && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CtrWeakNt;
      end
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (wr_en) begin
        valid_q[idx_e]  <= 1'b1;
        tag_q[idx_e]    <= wr_tag;
        target_q[idx_e] <= wr_target;
        ctr_q[idx_e]    <= wr_ctr;
      end
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

endmodule
